axi_mem_slave_if: RTL and testbench
===================================

# axi_mem_slave_if

AXI4 slave front-end for the simulation host-memory model: accepts full-width INCR write and read bursts from the shell master under test and converts them into single-beat, byte-masked accesses on one host-memory port (write address/data/mask, read enable/address, one-cycle-latency read data). It sits directly upstream of the dual-port host memory model; two instances drive its two ports.

## Interface

- DATA_WIDTH, 512, AXI data and memory word width (bits)
- ADDR_WIDTH, 64, byte address width
- MASK_WIDTH, DATA_WIDTH/8, byte lanes; ADDR_ALIGN_BITS = $clog2(MASK_WIDTH)

- clk  in  1  single clock for AXI and memory port
- rst  in  1  synchronous, active-high reset
- s_awvalid / s_awready  in / out  1  write-address handshake
- s_awaddr  in  ADDR_WIDTH  burst start byte address
- s_awlen  in  8  beats minus one
- s_wvalid / s_wready  in / out  1  write-data handshake
- s_wdata  in  DATA_WIDTH  write beat
- s_wstrb  in  MASK_WIDTH  byte strobes
- s_wlast  in  1  last write beat
- s_bvalid / s_bready  out / in  1  write-response handshake
- s_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- s_arvalid / s_arready  in / out  1  read-address handshake
- s_araddr  in  ADDR_WIDTH  burst start byte address
- s_arlen  in  8  beats minus one
- s_rvalid / s_rready  out / in  1  read-data handshake
- s_rdata  out  DATA_WIDTH  read beat (rresp implicitly OKAY)
- s_rlast  out  1  last read beat
- mem_wr_data  out  DATA_WIDTH  registered write word
- mem_wr_datamask  out  MASK_WIDTH  registered byte-write enables; zero when idle
- mem_wr_addr  out  ADDR_WIDTH  registered write byte address, aligned
- mem_rd_en  out  1  read request, one-cycle pulse per beat
- mem_rd_addr  out  ADDR_WIDTH  registered read byte address, aligned
- mem_rd_data  in  DATA_WIDTH  read word, valid with mem_rd_data_vld
- mem_rd_data_vld  in  1  asserted the cycle after mem_rd_en

## Operation

- Single outstanding burst per direction, IDs not supported, responses in order. Write and read FSMs are independent; there is no ordering between channels.
- Addressing: start address aligned down (low ADDR_ALIGN_BITS forced 0). Beat n address = aligned start + n*MASK_WIDTH, modulo 2^ADDR_WIDTH. No 4 KB boundary check. awsize/arsize/burst are not ports; every burst is full-width INCR.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: s_awready=1. On AW handshake, latch address and awlen, clear beat counter, go to W_DATA.
  - W_DATA: s_wready=1. Each W handshake registers wdata/wstrb/beat address onto mem_wr_* for exactly one cycle (mask=wstrb; mask=0 in all other cycles) and increments the counter.
  - The burst ends on wlast or when count reaches awlen+1, whichever comes first. bresp=OKAY only if both occur on the same beat, else SLVERR. The next state is W_RESP.
  - W_RESP: s_bvalid=1 held until s_bready, then W_IDLE.
- Read FSM R_IDLE -> R_ISSUE -> R_WAIT -> R_DATA.
  - R_IDLE: s_arready=1. On AR handshake, latch address and arlen, go to R_ISSUE.
  - R_ISSUE: mem_rd_en=1 with the beat address, go to R_WAIT.
  - R_WAIT: capture mem_rd_data when mem_rd_data_vld is high, go to R_DATA. If vld is absent, stay in R_WAIT.
  - R_DATA: s_rvalid=1, s_rdata/s_rlast held stable until s_rready. s_rlast=1 on beat arlen. After the handshake, go to R_ISSUE for the next beat, or R_IDLE after the last beat.
- Reset (including mid-burst): both FSMs go to idle and the counters clear. Bursts in flight are dropped with no B/R response.
- Reset values of all outputs: s_awready=0, s_wready=0, s_bvalid=0, s_bresp=0, s_arready=0, s_rvalid=0, s_rlast=0, s_rdata=0, mem_wr_datamask=0, mem_wr_data=0, mem_wr_addr=0, mem_rd_en=0, mem_rd_addr=0. The ready signals rise the cycle after rst deasserts.

## Timing

- AW handshake at cycle T: s_wready high from T+1. A W beat accepted at cycle U appears on mem_wr_* in U+1 and is written to memory at the end of U+1. Write throughput is 1 beat/cycle.
- Last W beat at cycle U: s_bvalid high from U+1. AW is accepted again the cycle after the B handshake.
- AR handshake at T: mem_rd_en in T+1, mem_rd_data_vld in T+2, s_rvalid from T+3. An R handshake at V for a non-last beat gives the next mem_rd_en at V+1. Read throughput is 1 beat per 3 cycles with rready held high.
- Read and write in the same cycle to the same word: the read returns the pre-write data, because the memory samples before the write lands.

## Test plan

- Reset mid-write burst (awlen=7, after 3 beats): no B response, mem_wr_datamask=0 from the reset cycle, s_awready=1 one cycle after rst falls.
- AW addr=0x1000, awlen=3, wstrb=all-ones, wdata=k (beats k=0..3), wlast on beat 3: mem_wr_addr=0x1000, 0x1040, 0x1080, 0x10C0 on consecutive cycles; bresp=OKAY.
- Unaligned AW addr=0x1023, awlen=0, wstrb=0x1: mem_wr_addr=0x1000 and mask=0x1. Then AR of the same address, arlen=0: rdata byte0 = written byte, rlast=1, rvalid at T+3.
- Protocol errors: wlast on beat 1 with awlen=3 -> burst ends after 2 beats, bresp=SLVERR. No wlast with awlen=1 -> ends after 2 beats, bresp=SLVERR.
- AR awlen=255 at addr=0xFFFF_FFFF_FFFF_FFC0 with random rready stalls: 256 beats in order, the second beat address wraps to 0x0, rdata stable while stalled, rlast only on beat 255.
- Simultaneous AW and AR bursts (awlen=15, arlen=15) to disjoint regions: both complete, write at 1 beat/cycle, read at 1 beat per 3 cycles, data intact.

Source files
------------

// File: rtl/axi_mem_slave_if.sv
// AXI4 INCR-burst slave that turns bursts into single-beat, byte-masked host-memory accesses.
// Latency: W beat -> mem_wr_* next cycle; AR -> mem_rd_en +1, s_rvalid +3 (one read beat every 3 cycles).
// Backpressure: one burst in flight per direction; B and R hold until s_bready/s_rready, stalling the next AW/AR.
module axi_mem_slave_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [MASK_WIDTH-1:0] s_wstrb,
    input  logic                  s_wlast,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_rlast,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [MASK_WIDTH-1:0] mem_wr_datamask,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_data_vld
);
    localparam int ADDR_ALIGN_BITS = $clog2(MASK_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(MASK_WIDTH);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DATA} r_state_e;

    function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:ADDR_ALIGN_BITS], {ADDR_ALIGN_BITS{1'b0}}};
    endfunction

    // run_q holds the address readies low for the first cycle after reset
    logic run_q, run_d;

    w_state_e               w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [7:0]             wlen_q, wlen_d;
    logic [7:0]             wcnt_q, wcnt_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [DATA_WIDTH-1:0]  mem_wr_data_q, mem_wr_data_d;
    logic [MASK_WIDTH-1:0]  mem_wr_datamask_q, mem_wr_datamask_d;
    logic [ADDR_WIDTH-1:0]  mem_wr_addr_q, mem_wr_addr_d;

    r_state_e               r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
    logic [7:0]             rlen_q, rlen_d;
    logic [7:0]             rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

    assign run_d = 1'b1;

    assign s_awready       = run_q && (w_state_q == W_IDLE);
    assign s_wready        = (w_state_q == W_DATA);
    assign s_bvalid        = (w_state_q == W_RESP);
    assign s_bresp         = bresp_q;
    assign mem_wr_data     = mem_wr_data_q;
    assign mem_wr_datamask = mem_wr_datamask_q;
    assign mem_wr_addr     = mem_wr_addr_q;

    assign s_arready   = run_q && (r_state_q == R_IDLE);
    assign mem_rd_en   = (r_state_q == R_ISSUE);
    assign mem_rd_addr = raddr_q;
    assign s_rvalid    = (r_state_q == R_DATA);
    assign s_rdata     = rdata_q;
    assign s_rlast     = (r_state_q == R_DATA) && (rcnt_q == rlen_q);

    // Write FSM: accept AW, stream beats onto the memory port, then hold B until taken
    always_comb begin
        w_state_d         = w_state_q;
        waddr_d           = waddr_q;
        wlen_d            = wlen_q;
        wcnt_d            = wcnt_q;
        bresp_d           = bresp_q;
        mem_wr_data_d     = mem_wr_data_q;
        mem_wr_addr_d     = mem_wr_addr_q;
        mem_wr_datamask_d = '0;
        case (w_state_q)
            W_IDLE: begin
                if (s_awvalid && s_awready) begin
                    waddr_d   = align(s_awaddr);
                    wlen_d    = s_awlen;
                    wcnt_d    = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_wvalid) begin
                    mem_wr_data_d     = s_wdata;
                    mem_wr_datamask_d = s_wstrb;
                    mem_wr_addr_d     = waddr_q;
                    waddr_d           = waddr_q + BEAT_BYTES;
                    wcnt_d            = wcnt_q + 8'd1;
                    // Burst closes on whichever of wlast / final counted beat comes first
                    if (s_wlast || (wcnt_q == wlen_q)) begin
                        bresp_d   = (s_wlast && (wcnt_q == wlen_q)) ? RESP_OKAY : RESP_SLVERR;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM: one memory request per beat, hold the returned word until R handshake
    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_arvalid && s_arready) begin
                    raddr_d   = align(s_araddr);
                    rlen_d    = s_arlen;
                    rcnt_d    = '0;
                    r_state_d = R_ISSUE;
                end
            end
            R_ISSUE: r_state_d = R_WAIT;
            R_WAIT: begin
                if (mem_rd_data_vld) begin
                    rdata_d   = mem_rd_data;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        rcnt_d    = rcnt_q + 8'd1;
                        raddr_d   = raddr_q + BEAT_BYTES;
                        r_state_d = R_ISSUE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Reset-release flag for the address readies
    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= run_d;
    end

    // Write-side state and memory write port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q         <= W_IDLE;
            waddr_q           <= '0;
            wlen_q            <= '0;
            wcnt_q            <= '0;
            bresp_q           <= RESP_OKAY;
            mem_wr_data_q     <= '0;
            mem_wr_datamask_q <= '0;
            mem_wr_addr_q     <= '0;
        end else begin
            w_state_q         <= w_state_d;
            waddr_q           <= waddr_d;
            wlen_q            <= wlen_d;
            wcnt_q            <= wcnt_d;
            bresp_q           <= bresp_d;
            mem_wr_data_q     <= mem_wr_data_d;
            mem_wr_datamask_q <= mem_wr_datamask_d;
            mem_wr_addr_q     <= mem_wr_addr_d;
        end
    end

    // Read-side state, beat address and captured read word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_slave_if.sv
// Scoreboard bench for axi_mem_slave_if with a behavioural host-memory model.
// Latency: expected mem writes, B and R beats are queued at issue and popped by a negedge monitor.
// Backpressure: s_rready is randomly stalled in one phase; s_bready is held high.
module tb_axi_mem_slave_if;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          s_awvalid, s_awready;
    logic [AW-1:0] s_awaddr;
    logic [7:0]    s_awlen;
    logic          s_wvalid, s_wready;
    logic [DW-1:0] s_wdata;
    logic [MW-1:0] s_wstrb;
    logic          s_wlast;
    logic          s_bvalid, s_bready;
    logic [1:0]    s_bresp;
    logic          s_arvalid, s_arready;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;
    logic          s_rvalid, s_rready;
    logic [DW-1:0] s_rdata;
    logic          s_rlast;
    logic [DW-1:0] mem_wr_data;
    logic [MW-1:0] mem_wr_datamask;
    logic [AW-1:0] mem_wr_addr;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          mem_rd_data_vld = 1'b0;

    axi_mem_slave_if dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
        .mem_wr_data(mem_wr_data), .mem_wr_datamask(mem_wr_datamask), .mem_wr_addr(mem_wr_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_data_vld(mem_rd_data_vld)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    // Host memory model: unwritten words read as the address replicated; read samples before write
    logic [DW-1:0] mem [logic [63:0]];
    function automatic logic [DW-1:0] dflt(input logic [63:0] a);
        return {8{a}};
    endfunction

    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (mem_rd_en) mem_rd_data <= mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : dflt(mem_rd_addr);
        mem_rd_data_vld <= mem_rd_en;
        if (mem_wr_datamask != '0) begin
            w = mem.exists(mem_wr_addr) ? mem[mem_wr_addr] : dflt(mem_wr_addr);
            for (int b = 0; b < MW; b++)
                if (mem_wr_datamask[b]) w[b*8 +: 8] = mem_wr_data[b*8 +: 8];
            mem[mem_wr_addr] = w;
        end
    end

    typedef struct { logic [63:0] addr; logic [DW-1:0] data; logic [MW-1:0] mask; bit consec; } wr_t;
    typedef struct { logic [DW-1:0] data; bit last; int cyc; } rd_t;
    wr_t         exp_wr[$];
    logic [1:0]  exp_b[$];
    logic [63:0] exp_ra[$];
    rd_t         exp_r[$];

    // Monitor state
    wr_t           we_;
    rd_t           re_;
    logic [1:0]    be_;
    logic [63:0]   ra_;
    int            last_wr_cyc = -10;
    bit            held = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;

    // Monitor: pop and compare whenever the DUT presents an output event
    always @(negedge clk) if (cyc >= 1) begin
        if (mem_wr_datamask != '0) begin
            if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_mem_wr: addr 0x%0h mask 0x%0h, required no write", mem_wr_addr, mem_wr_datamask);
            end else begin
                we_ = exp_wr.pop_front();
                check("mem_wr_addr", mem_wr_addr, we_.addr);
                check("mem_wr_data", mem_wr_data, we_.data);
                check("mem_wr_datamask", mem_wr_datamask, we_.mask);
                if (we_.consec) check("wr_back_to_back_cycle", cyc, last_wr_cyc + 1);
            end
            last_wr_cyc = cyc;
        end
        if (s_bvalid && s_bready) begin
            if (exp_b.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_bresp: got bvalid resp %0d, required none", s_bresp);
            end else begin
                be_ = exp_b.pop_front();
                check("bresp", s_bresp, be_);
                check("bvalid_cycle", cyc, last_wr_cyc);
            end
        end
        if (mem_rd_en) begin
            if (exp_ra.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_mem_rd: addr 0x%0h, required no read", mem_rd_addr);
            end else begin
                ra_ = exp_ra.pop_front();
                check("mem_rd_addr", mem_rd_addr, ra_);
            end
        end
        if (s_rvalid) begin
            if (held) begin
                check("rdata_stable", s_rdata, held_data);
                check("rlast_stable", s_rlast, held_last);
            end
            if (s_rready) begin
                held = 1'b0;
                if (exp_r.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_rbeat: got rdata 0x%0h, required none", s_rdata);
                end else begin
                    re_ = exp_r.pop_front();
                    check("rdata", s_rdata, re_.data);
                    check("rlast", s_rlast, re_.last);
                    if (re_.cyc >= 0) check("rbeat_cycle", cyc, re_.cyc);
                end
            end else begin
                held = 1'b1;
                held_data = s_rdata;
                held_last = s_rlast;
            end
        end
    end

    // R-channel ready driver; random stalls when stall_mode is set
    bit stall_mode = 1'b0;
    initial begin
        s_rready = 1'b1;
        forever begin
            @(posedge clk); #1;
            s_rready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Hold current valid until the chosen ready is seen (0=AW, 1=W, 2=AR), bounded
    task automatic hs(input int ch);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = (ch == 0) ? s_awready : (ch == 1) ? s_wready : s_arready;
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL handshake_timeout: channel %0d ready low for %0d cycles, required high", ch, n);
        end
    endtask

    task automatic aw_send(input logic [63:0] a, input logic [7:0] l);
        s_awvalid = 1'b1; s_awaddr = a; s_awlen = l;
        hs(0);
        s_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [MW-1:0] s, input bit l);
        s_wvalid = 1'b1; s_wdata = d; s_wstrb = s; s_wlast = l;
        hs(1);
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    task automatic ar_send(input logic [63:0] a, input logic [7:0] l, output int tc);
        s_arvalid = 1'b1; s_araddr = a; s_arlen = l;
        hs(2);
        s_arvalid = 1'b0;
        tc = cyc;
    endtask

    task automatic push_wr(input logic [63:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m, input bit c);
        wr_t e;
        e.addr = a; e.data = d; e.mask = m; e.consec = c;
        exp_wr.push_back(e);
    endtask

    task automatic push_r(input logic [DW-1:0] d, input bit l, input int c);
        rd_t e;
        e.data = d; e.last = l; e.cyc = c;
        exp_r.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        int pend;
        n = 0;
        pend = exp_wr.size() + exp_b.size() + exp_ra.size() + exp_r.size();
        while (pend != 0 && n < budget) begin
            @(posedge clk); n++;
            pend = exp_wr.size() + exp_b.size() + exp_ra.size() + exp_r.size();
        end
        check("outstanding_after_drain", pend, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    localparam logic [MW-1:0] ALL = {MW{1'b1}};

    initial begin
        int tc;
        logic [63:0] a;
        logic [DW-1:0] d;
        rst = 1'b1;
        s_awvalid = 0; s_awaddr = '0; s_awlen = '0;
        s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_wlast = 0;
        s_bready = 1'b1;
        s_arvalid = 0; s_araddr = '0; s_arlen = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", s_awready, 0);
        check("rst_wready", s_wready, 0);
        check("rst_bvalid", s_bvalid, 0);
        check("rst_bresp", s_bresp, 0);
        check("rst_arready", s_arready, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_rlast", s_rlast, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_mem_wr_datamask", mem_wr_datamask, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_mem_wr_addr", mem_wr_addr, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        rst = 1'b0;
        check("awready_first_cycle_after_rst", s_awready, 0);
        @(posedge clk); #1;
        check("awready_after_rst", s_awready, 1);
        check("arready_after_rst", s_arready, 1);

        // 256-beat read at top of address space with random rready stalls; beat 1 wraps to 0
        stall_mode = 1'b1;
        for (int k = 0; k < 256; k++) begin
            a = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFC0 : 64'((k - 1) * 64);
            exp_ra.push_back(a);
        end
        ar_send(64'hFFFF_FFFF_FFFF_FFC0, 8'd255, tc);
        for (int k = 0; k < 256; k++) begin
            a = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFC0 : 64'((k - 1) * 64);
            push_r(dflt(a), k == 255, -1);
        end
        drain(6000);
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an 8-beat write after 3 beats
        aw_send(64'h8000, 8'd7);
        for (int k = 0; k < 3; k++) push_wr(64'h8000 + 64'(k * 64), DW'(32'hB0 + k), ALL, k > 0);
        for (int k = 0; k < 3; k++) w_send(DW'(32'hB0 + k), ALL, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_datamask", mem_wr_datamask, 0);
        check("midrst_wready", s_wready, 0);
        check("midrst_bvalid", s_bvalid, 0);
        rst = 1'b0;
        check("midrst_awready_during_release", s_awready, 0);
        @(posedge clk); #1;
        check("midrst_awready_after", s_awready, 1);
        drain(50);

        // Aligned 4-beat full-strobe burst
        for (int k = 0; k < 4; k++) push_wr(64'h1000 + 64'(k * 64), DW'(k), ALL, k > 0);
        exp_b.push_back(2'b00);
        aw_send(64'h1000, 8'd3);
        for (int k = 0; k < 4; k++) w_send(DW'(k), ALL, k == 3);
        drain(100);

        // Unaligned single-byte write, then read it back
        d = {{63{8'hEE}}, 8'hA5};
        push_wr(64'h1000, d, 64'h1, 1'b0);
        exp_b.push_back(2'b00);
        aw_send(64'h1023, 8'd0);
        w_send(d, 64'h1, 1'b1);
        drain(100);
        exp_ra.push_back(64'h1000);
        ar_send(64'h1023, 8'd0, tc);
        push_r(DW'(8'hA5), 1'b1, tc + 2);
        drain(100);

        // Early wlast: awlen=3, wlast on beat 1
        push_wr(64'h2000, DW'(32'hC0), ALL, 1'b0);
        push_wr(64'h2040, DW'(32'hC1), ALL, 1'b1);
        exp_b.push_back(2'b10);
        aw_send(64'h2000, 8'd3);
        w_send(DW'(32'hC0), ALL, 1'b0);
        w_send(DW'(32'hC1), ALL, 1'b1);
        drain(100);

        // Missing wlast: awlen=1, neither beat flagged last
        push_wr(64'h3000, DW'(32'hD0), ALL, 1'b0);
        push_wr(64'h3040, DW'(32'hD1), ALL, 1'b1);
        exp_b.push_back(2'b10);
        aw_send(64'h3000, 8'd1);
        w_send(DW'(32'hD0), ALL, 1'b0);
        w_send(DW'(32'hD1), ALL, 1'b0);
        drain(100);

        // Concurrent 16-beat write and 16-beat read to disjoint regions
        for (int k = 0; k < 16; k++) begin
            push_wr(64'h2_0000 + 64'(k * 64), {16{32'h5000_0000 + 32'(k)}}, ALL, k > 0);
            exp_ra.push_back(64'h3_0000 + 64'(k * 64));
        end
        exp_b.push_back(2'b00);
        fork
            begin
                aw_send(64'h2_0000, 8'd15);
                for (int k = 0; k < 16; k++) w_send({16{32'h5000_0000 + 32'(k)}}, ALL, k == 15);
            end
            begin
                int t2;
                ar_send(64'h3_0000, 8'd15, t2);
                for (int k = 0; k < 16; k++)
                    push_r(dflt(64'h3_0000 + 64'(k * 64)), k == 15, t2 + 2 + 3 * k);
            end
        join
        drain(300);

        // Read back the concurrently written region
        for (int k = 0; k < 16; k++) exp_ra.push_back(64'h2_0000 + 64'(k * 64));
        ar_send(64'h2_0000, 8'd15, tc);
        for (int k = 0; k < 16; k++) push_r({16{32'h5000_0000 + 32'(k)}}, k == 15, tc + 2 + 3 * k);
        drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
